// File: rtl/riscv_v_lmul_seq_if.sv
// Handshake bundle between vector decode, the LMUL sequencer and the datapath.
// The sequencer takes the slave view; the surrounding pipe takes the master view.
interface riscv_v_lmul_seq_if #(
    parameter int ADDR_W = 5,
    parameter int VL_W   = 8,
    parameter int CNT_W  = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_vs1;
    logic [ADDR_W-1:0] in_vs2;
    logic [ADDR_W-1:0] in_vd;
    logic              in_vs1_scalar;
    logic              in_vd_fixed;
    logic [2:0]        in_vlmul;
    logic [2:0]        in_vsew;
    logic [VL_W-1:0]   in_vl;

    logic              uop_valid;
    logic              uop_ready;
    logic [ADDR_W-1:0] uop_vs1;
    logic [ADDR_W-1:0] uop_vs2;
    logic [ADDR_W-1:0] uop_vd;
    logic [2:0]        uop_idx;
    logic              uop_first;
    logic              uop_last;
    logic [CNT_W-1:0]  uop_elem_cnt;

    modport master (
        output in_valid, in_vs1, in_vs2, in_vd,
        output in_vs1_scalar, in_vd_fixed,
        output in_vlmul, in_vsew, in_vl,
        output uop_ready,
        input  in_ready,
        input  uop_valid, uop_vs1, uop_vs2, uop_vd,
        input  uop_idx, uop_first, uop_last, uop_elem_cnt
    );

    modport slave (
        input  in_valid, in_vs1, in_vs2, in_vd,
        input  in_vs1_scalar, in_vd_fixed,
        input  in_vlmul, in_vsew, in_vl,
        input  uop_ready,
        output in_ready,
        output uop_valid, uop_vs1, uop_vs2, uop_vd,
        output uop_idx, uop_first, uop_last, uop_elem_cnt
    );
endinterface

// File: rtl/riscv_v_lmul_seq.sv
// LMUL register-group sequencer: splits one decoded vector instruction
// into one micro-op per physical register of its group.
module riscv_v_lmul_seq #(
    parameter int ADDR_W = 5,
    parameter int VLEN   = 128,
    parameter int VL_W   = 8,
    parameter int CNT_W  = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    riscv_v_lmul_seq_if.slave    bus,
    output logic                 seq_stall,
    output logic                 done,
    output logic                 illegal
);
    localparam int EMAX = VLEN / 8;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ISSUE = 1'b1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] vs1_q;
    logic [ADDR_W-1:0] vs2_q;
    logic [ADDR_W-1:0] vd_q;
    logic              scalar_q;
    logic              fixed_q;
    logic [CNT_W-1:0]  e_q;
    logic [VL_W-1:0]   rem_q;
    logic [2:0]        idx_q;
    logic [2:0]        lmax_q;

    logic [1:0]        sh;
    logic [2:0]        lm1;
    logic [CNT_W-1:0]  e_in;
    logic [VL_W-1:0]   vlmax;
    logic [VL_W-1:0]   vl_eff;
    logic              misal;
    logic              bad;
    logic              valid;
    logic              rem_le_e;
    logic              last_c;
    logic [CNT_W-1:0]  cnt_c;

    // Fractional and reserved LMUL collapse to a one-register group.
    always_comb begin
        sh = 2'd0;
        unique case (1'b1)
            bus.in_vlmul[2]:  sh = 2'd0;
            !bus.in_vlmul[2]: sh = bus.in_vlmul[1:0];
            default:          sh = 2'd0;
        endcase
        lm1    = 3'((4'd1 << sh) - 4'd1);
        e_in   = CNT_W'(EMAX >> bus.in_vsew[1:0]);
        vlmax  = VL_W'(e_in) << sh;
        vl_eff = (bus.in_vl < vlmax) ? bus.in_vl : vlmax;
        misal  = ((bus.in_vs2[2:0] & lm1) != 3'd0)
               | (!bus.in_vs1_scalar && ((bus.in_vs1[2:0] & lm1) != 3'd0))
               | (!bus.in_vd_fixed && ((bus.in_vd[2:0] & lm1) != 3'd0));
        bad    = (bus.in_vlmul == 3'd4) | bus.in_vsew[2] | misal;
    end

    assign valid    = (state == ISSUE);
    assign rem_le_e = (rem_q <= VL_W'(e_q));
    assign last_c   = rem_le_e | (idx_q == lmax_q);
    assign cnt_c    = rem_le_e ? CNT_W'(rem_q) : e_q;

    assign bus.in_ready     = (state == IDLE);
    assign bus.uop_valid    = valid;
    assign bus.uop_vs1      = valid ? vs1_q : '0;
    assign bus.uop_vs2      = valid ? vs2_q : '0;
    assign bus.uop_vd       = valid ? vd_q : '0;
    assign bus.uop_idx      = valid ? idx_q : '0;
    assign bus.uop_first    = valid & (idx_q == 3'd0);
    assign bus.uop_last     = valid & last_c;
    assign bus.uop_elem_cnt = valid ? cnt_c : '0;

    // Release the scalar pipe in the same cycle the last uop leaves.
    assign seq_stall = valid & ~(bus.uop_ready & last_c);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            vs1_q    <= '0;
            vs2_q    <= '0;
            vd_q     <= '0;
            scalar_q <= 1'b0;
            fixed_q  <= 1'b0;
            e_q      <= '0;
            rem_q    <= '0;
            idx_q    <= '0;
            lmax_q   <= '0;
            done     <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            done    <= 1'b0;
            illegal <= 1'b0;
            if (flush) begin
                state <= IDLE;
            end else if (state == IDLE) begin
                if (bus.in_valid) begin
                    vs1_q    <= bus.in_vs1;
                    vs2_q    <= bus.in_vs2;
                    vd_q     <= bus.in_vd;
                    scalar_q <= bus.in_vs1_scalar;
                    fixed_q  <= bus.in_vd_fixed;
                    e_q      <= e_in;
                    rem_q    <= vl_eff;
                    idx_q    <= 3'd0;
                    lmax_q   <= lm1;
                    if (bad)
                        illegal <= 1'b1;
                    else if (vl_eff == '0)
                        done <= 1'b1;
                    else
                        state <= ISSUE;
                end
            end else if (bus.uop_ready) begin
                if (last_c) begin
                    state <= IDLE;
                    done  <= 1'b1;
                end else begin
                    idx_q <= idx_q + 3'd1;
                    rem_q <= rem_q - VL_W'(e_q);
                    vs2_q <= vs2_q + ADDR_W'(1);
                    if (!scalar_q)
                        vs1_q <= vs1_q + ADDR_W'(1);
                    if (!fixed_q)
                        vd_q <= vd_q + ADDR_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_riscv_v_lmul_seq.sv
// Scoreboard bench for the LMUL sequencer: directed instructions push
// expected uops/done/illegal events; a negedge monitor pops and compares.
module tb_riscv_v_lmul_seq;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0;
    logic seq_stall, done, illegal;

    riscv_v_lmul_seq_if bus ();

    riscv_v_lmul_seq dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .bus       (bus.slave),
        .seq_stall (seq_stall),
        .done      (done),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         kind;
        logic [4:0] vs1, vs2, vd;
        logic [2:0] idx;
        logic       first, last;
        logic [4:0] cnt;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    exp_t snap;
    logic prev_hold = 1'b0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic push_uop(input int vs1, vs2, vd, idx, first, last, cnt);
        exp_t x;
        x.kind = 0; x.vs1 = 5'(vs1); x.vs2 = 5'(vs2); x.vd = 5'(vd);
        x.idx = 3'(idx); x.first = 1'(first); x.last = 1'(last);
        x.cnt = 5'(cnt);
        sb.push_back(x);
    endtask

    task automatic push_ev(input int kind);
        exp_t x;
        x = '{kind: kind, default: '0};
        sb.push_back(x);
    endtask

    task automatic issue(input int vs1, vs2, vd, input bit sc, fx,
                         input int lmul, sew, vl);
        int n = 0;
        while (!bus.in_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk("in_ready_wait", bus.in_ready, 1);
        bus.in_vs1 = 5'(vs1); bus.in_vs2 = 5'(vs2); bus.in_vd = 5'(vd);
        bus.in_vs1_scalar = sc; bus.in_vd_fixed = fx;
        bus.in_vlmul = 3'(lmul); bus.in_vsew = 3'(sew); bus.in_vl = 8'(vl);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk); #1; n++;
        end
        chk("drain_pending", sb.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            prev_hold = 1'b0;
        end else begin
            if (bus.uop_valid) begin
                chk("in_ready_busy", bus.in_ready, 0);
                if (prev_hold) begin
                    chk("hold_vs1", bus.uop_vs1, snap.vs1);
                    chk("hold_vs2", bus.uop_vs2, snap.vs2);
                    chk("hold_vd", bus.uop_vd, snap.vd);
                    chk("hold_idx", bus.uop_idx, snap.idx);
                    chk("hold_cnt", bus.uop_elem_cnt, snap.cnt);
                end
                if (bus.uop_ready) begin
                    chk("stall_accept", seq_stall, bus.uop_last ? 0 : 1);
                    if (sb.size() == 0 || sb[0].kind != 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_uop actual idx %0d vs2 %0d required none",
                                 bus.uop_idx, bus.uop_vs2);
                    end else begin
                        e = sb.pop_front();
                        chk("uop_vs1", bus.uop_vs1, e.vs1);
                        chk("uop_vs2", bus.uop_vs2, e.vs2);
                        chk("uop_vd", bus.uop_vd, e.vd);
                        chk("uop_idx", bus.uop_idx, e.idx);
                        chk("uop_first", bus.uop_first, e.first);
                        chk("uop_last", bus.uop_last, e.last);
                        chk("uop_cnt", bus.uop_elem_cnt, e.cnt);
                    end
                end else begin
                    chk("stall_bp", seq_stall, 1);
                end
            end else begin
                chk("stall_idle", seq_stall, 0);
            end
            prev_hold = bus.uop_valid & ~bus.uop_ready;
            snap.vs1 = bus.uop_vs1; snap.vs2 = bus.uop_vs2; snap.vd = bus.uop_vd;
            snap.idx = bus.uop_idx; snap.cnt = bus.uop_elem_cnt;
            if (done) begin
                if (sb.size() == 0 || sb[0].kind != 1) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done actual 1 required 0");
                end else begin
                    e = sb.pop_front();
                    chk("done_pulse", done, 1);
                end
            end
            if (illegal) begin
                if (sb.size() == 0 || sb[0].kind != 2) begin
                    checks++; errors++;
                    $display("FAIL unexpected_illegal actual 1 required 0");
                end else begin
                    e = sb.pop_front();
                    chk("illegal_pulse", illegal, 1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout actual running required finished");
        $fatal(1);
    end

    initial begin
        bus.in_valid = 1'b0; bus.in_vs1 = '0; bus.in_vs2 = '0; bus.in_vd = '0;
        bus.in_vs1_scalar = 1'b0; bus.in_vd_fixed = 1'b0;
        bus.in_vlmul = '0; bus.in_vsew = '0; bus.in_vl = '0;
        bus.uop_ready = 1'b1;
        #12;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_uop_valid", bus.uop_valid, 0);
        chk("rst_stall", seq_stall, 0);
        chk("rst_done", done, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_uop_vs2", bus.uop_vs2, 0);
        chk("rst_uop_cnt", bus.uop_elem_cnt, 0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        // LMUL=1 single uop
        push_uop(3, 5, 7, 0, 1, 1, 16); push_ev(1);
        issue(3, 5, 7, 0, 0, 0, 0, 16);
        drain();

        // LMUL=4, SEW=32, vl=10 -> 3 uops
        push_uop(4, 8, 12, 0, 1, 0, 4);
        push_uop(5, 9, 13, 1, 0, 0, 4);
        push_uop(6, 10, 14, 2, 0, 1, 2); push_ev(1);
        issue(4, 8, 12, 0, 0, 2, 2, 10);
        drain();

        // same with backpressure on uop 1
        push_uop(4, 8, 12, 0, 1, 0, 4);
        push_uop(5, 9, 13, 1, 0, 0, 4);
        push_uop(6, 10, 14, 2, 0, 1, 2); push_ev(1);
        issue(4, 8, 12, 0, 0, 2, 2, 10);
        @(posedge clk); #1;
        bus.uop_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.uop_ready = 1'b1;
        drain();

        // vl=0 and misaligned vd
        push_ev(1);
        issue(1, 2, 3, 0, 0, 0, 0, 0);
        drain();
        push_ev(2);
        issue(2, 4, 13, 0, 0, 1, 0, 8);
        chk("illegal_in_ready", bus.in_ready, 1);
        drain();

        // reserved vlmul and vsew
        push_ev(2);
        issue(0, 0, 0, 0, 0, 4, 0, 8);
        drain();
        push_ev(2);
        issue(0, 0, 0, 0, 0, 0, 4, 8);
        drain();

        // vl above VLMAX clamps; fractional LMUL gives one uop
        push_uop(1, 2, 3, 0, 1, 1, 2); push_ev(1);
        issue(1, 2, 3, 0, 0, 0, 3, 200);
        drain();
        push_uop(6, 7, 9, 0, 1, 1, 5); push_ev(1);
        issue(6, 7, 9, 0, 0, 7, 1, 5);
        drain();

        // LMUL=8 with scalar vs1 and fixed vd
        for (int i = 0; i < 8; i++)
            push_uop(3, 16 + i, 5, i, i == 0, i == 7, 16);
        push_ev(1);
        issue(3, 16, 5, 1, 1, 3, 0, 128);
        drain();

        // flush during uop 1
        push_uop(3, 16, 5, 0, 1, 0, 16);
        issue(3, 16, 5, 1, 1, 3, 0, 128);
        @(posedge clk); #1;
        bus.uop_ready = 1'b0;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_valid", bus.uop_valid, 0);
        chk("flush_done", done, 0);
        chk("flush_in_ready", bus.in_ready, 1);
        bus.uop_ready = 1'b1;
        drain();

        // flush coinciding with accept drops the instruction
        flush = 1'b1;
        issue(3, 5, 7, 0, 0, 0, 0, 16);
        flush = 1'b0;
        chk("flush_drop_valid", bus.uop_valid, 0);
        drain();

        // asynchronous reset mid-group
        push_uop(3, 16, 5, 0, 1, 0, 16);
        issue(3, 16, 5, 1, 1, 3, 0, 128);
        @(posedge clk); #1;
        bus.uop_ready = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", bus.uop_valid, 0);
        chk("arst_stall", seq_stall, 0);
        chk("arst_in_ready", bus.in_ready, 1);
        chk("arst_vs2", bus.uop_vs2, 0);
        chk("arst_first", bus.uop_first, 0);
        @(negedge clk) rst = 1'b1;
        bus.uop_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
